// File: rtl/m_cache_nway.sv
// N-way set-associative read-only instruction cache (1-word lines) with miss refill FSM and flush.
// Optional hit/miss counters (r_hits, r_misses) are built only when CACHE_STAT_EN is defined.
module m_cache_nway #(
    parameter int WAYS = 2,
    parameter int SETS = 32,
    localparam int IB = $clog2(SETS)
) (
    input  logic        w_clk,
    input  logic        w_rst,
    input  logic        w_req,
    input  logic [31:0] w_adr,
    output logic        w_rdy,
    output logic [31:0] w_dout,
    output logic        w_busy,
    input  logic        w_inv,
    output logic        w_mre,
    output logic [31:0] w_madr,
    input  logic        w_moe,
    input  logic [31:0] w_mdata
`ifdef CACHE_STAT_EN
    ,
    output logic [31:0] r_hits,
    output logic [31:0] r_misses
`endif
);

    localparam int TW = 30 - IB;
    localparam int WB = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        MISS,
        FILL
    } state_t;

    state_t state_q, state_d;

    logic [WAYS-1:0] valid_q [SETS];
    logic [TW-1:0]   tag_q   [WAYS][SETS];
    logic [31:0]     data_q  [WAYS][SETS];

    logic [31:0] madr_q;
    logic [31:0] fill_q;
    logic        pend_inv_q;

    logic [IB-1:0] req_idx, miss_idx;
    logic [TW-1:0] req_tag, miss_tag;
    logic          hit;
    logic [31:0]   hit_data;
    logic          inv_found;
    logic [WB-1:0] victim, rr_way;
    logic          flush_now;
    logic          start_miss;
    logic [1:0]    unused_adr;

    assign req_idx    = w_adr[IB+1:2];
    assign req_tag    = w_adr[31:IB+2];
    assign miss_idx   = madr_q[IB+1:2];
    assign miss_tag   = madr_q[31:IB+2];
    assign unused_adr = w_adr[1:0];

    // Descending scan so the lowest matching way is the one left standing.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[req_idx][w] && (tag_q[w][req_idx] == req_tag)) begin
                hit      = 1'b1;
                hit_data = data_q[w][req_idx];
            end
        end
    end

    // Prefer the lowest invalid way; fall back to the set's round-robin pointer.
    always_comb begin
        inv_found = 1'b0;
        victim    = rr_way;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[miss_idx][w]) begin
                inv_found = 1'b1;
                victim    = WB'(w);
            end
        end
    end

    assign start_miss = (state_q == IDLE) && w_req && !hit;
    assign flush_now  = ((state_q == IDLE) && w_inv) ||
                        ((state_q == FILL) && (pend_inv_q || w_inv));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_miss) state_d = MISS;
            MISS:    if (w_moe) state_d = FILL;
            FILL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            madr_q     <= '0;
            pend_inv_q <= 1'b0;
        end else begin
            if (start_miss) madr_q <= {w_adr[31:2], 2'b00};
            if (state_q == IDLE) pend_inv_q <= 1'b0;
            else if (w_inv)      pend_inv_q <= 1'b1;
        end
    end

    always_ff @(posedge w_clk) begin
        if (!w_rst && (state_q == MISS) && w_moe) fill_q <= w_mdata;
    end

    // A flush pending at the end of a fill wins, so the just-fetched line is dropped.
    always_ff @(posedge w_clk) begin
        if (w_rst || flush_now) begin
            for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
        end else if (state_q == FILL) begin
            valid_q[miss_idx][victim] <= 1'b1;
        end
    end

    always_ff @(posedge w_clk) begin
        if (!w_rst && (state_q == FILL)) begin
            tag_q[victim][miss_idx]  <= miss_tag;
            data_q[victim][miss_idx] <= fill_q;
        end
    end

    generate
        if (WAYS > 1) begin : g_rr
            logic [WB-1:0] ptr_q [SETS];
            always_ff @(posedge w_clk) begin
                if (w_rst || flush_now) begin
                    for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
                end else if ((state_q == FILL) && !inv_found) begin
                    ptr_q[miss_idx] <= ptr_q[miss_idx] + 1'b1;
                end
            end
            assign rr_way = ptr_q[miss_idx];
        end else begin : g_dm
            assign rr_way = '0;
        end
    endgenerate

    assign w_rdy  = w_req && hit && (state_q == IDLE);
    assign w_dout = hit_data;
    assign w_busy = (state_q != IDLE);
    assign w_mre  = (state_q == MISS);
    assign w_madr = madr_q;

`ifdef CACHE_STAT_EN
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_hits   <= '0;
            r_misses <= '0;
        end else begin
            if (w_rdy)      r_hits   <= r_hits + 32'd1;
            if (start_miss) r_misses <= r_misses + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_m_cache_nway.sv
// Self-checking bench for m_cache_nway: directed miss/hit/replacement/flush/reset scenarios
// plus randomized fetches compared against an address-level cache model.
module tb_m_cache_nway;

    localparam int WAYS = 2;
    localparam int SETS = 32;

    logic        w_clk = 1'b0;
    logic        w_rst = 1'b1;
    logic        w_req = 1'b0;
    logic [31:0] w_adr = '0;
    logic        w_rdy;
    logic [31:0] w_dout;
    logic        w_busy;
    logic        w_inv = 1'b0;
    logic        w_mre;
    logic [31:0] w_madr;
    logic        w_moe = 1'b0;
    logic [31:0] w_mdata = '0;
`ifdef CACHE_STAT_EN
    logic [31:0] r_hits;
    logic [31:0] r_misses;
`endif

    int checks   = 0;
    int failures = 0;

    m_cache_nway #(.WAYS(WAYS), .SETS(SETS)) dut (
        .w_clk   (w_clk),
        .w_rst   (w_rst),
        .w_req   (w_req),
        .w_adr   (w_adr),
        .w_rdy   (w_rdy),
        .w_dout  (w_dout),
        .w_busy  (w_busy),
        .w_inv   (w_inv),
        .w_mre   (w_mre),
        .w_madr  (w_madr),
        .w_moe   (w_moe),
        .w_mdata (w_mdata)
`ifdef CACHE_STAT_EN
        ,
        .r_hits  (r_hits),
        .r_misses(r_misses)
`endif
    );

    always #5 w_clk = ~w_clk;

    // Reference model: which aligned addresses each way holds, plus per-set replacement pointer.
    bit          m_valid [WAYS][SETS];
    logic [31:0] m_addr  [WAYS][SETS];
    int          m_ptr   [SETS];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] al;
        al = a & ~32'h3;
        if (al == 32'h40) return 32'h0050_0093;
        return {al[15:0] ^ 16'hC3A5, al[31:16] ^ 16'h1234};
    endfunction

    function automatic int set_of(input logic [31:0] a);
        return int'((a >> 2) % SETS);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int s;
        s = set_of(a);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[w][s] && m_addr[w][s] == (a & ~32'h3)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_fill(input logic [31:0] a);
        int s, v;
        s = set_of(a);
        v = -1;
        for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[w][s]) v = w;
        if (v < 0) begin
            v = m_ptr[s];
            m_ptr[s] = (m_ptr[s] + 1) % WAYS;
        end
        m_valid[v][s] = 1'b1;
        m_addr[v][s]  = a & ~32'h3;
    endtask

    task automatic model_flush();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[w][s] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge w_clk);
        w_rst = 1'b1; w_req = 1'b0; w_inv = 1'b0; w_moe = 1'b0;
        repeat (2) @(negedge w_clk);
        w_rst = 1'b0;
        model_flush();
    endtask

    // Holds w_req until w_rdy, acting as a memory that answers in the lat-th MISS cycle.
    task automatic fetch(input logic [31:0] a, input int lat, input int inv_at,
                         output logic first_rdy, output logic first_mre,
                         output logic [31:0] dout, output int gap, output int nmiss,
                         output logic [31:0] madr_seen, output logic busy_seen,
                         output logic timeout);
        int cyc, mre_cnt, mre_total, moe_cyc;
        @(negedge w_clk);
        w_req = 1'b1; w_adr = a;
        #1;
        first_rdy = w_rdy; first_mre = w_mre;
        cyc = 0; mre_cnt = 0; mre_total = 0; moe_cyc = -100; nmiss = 0;
        madr_seen = '0; busy_seen = 1'b0;
        while (!w_rdy && cyc < 300) begin
            if (w_mre) begin
                if (mre_total == 0) begin
                    madr_seen = w_madr;
                    busy_seen = w_busy;
                end
                if (mre_total == inv_at) w_inv = 1'b1;
                mre_total++;
                mre_cnt++;
                if (mre_cnt == lat) begin
                    w_moe = 1'b1; w_mdata = mem_word(a);
                    moe_cyc = cyc; mre_cnt = 0; nmiss++;
                end
            end
            @(posedge w_clk);
            @(negedge w_clk);
            w_moe = 1'b0; w_inv = 1'b0; w_mdata = $urandom;
            #1;
            cyc++;
        end
        timeout = !w_rdy;
        gap = cyc - moe_cyc;
        dout = w_dout;
        @(negedge w_clk);
        w_req = 1'b0; w_adr = $urandom;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (w_rdy !== 1'b0) begin failures++; $display("[TB] FAIL reset_rdy: got %b want 0", w_rdy); end
        checks++; if (w_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b want 0", w_busy); end
        checks++; if (w_mre !== 1'b0) begin failures++; $display("[TB] FAIL reset_mre: got %b want 0", w_mre); end
        checks++; if (w_madr !== 32'h0) begin failures++; $display("[TB] FAIL reset_madr: got %h want 0", w_madr); end
        checks++; if (w_dout !== 32'h0) begin failures++; $display("[TB] FAIL reset_dout: got %h want 0", w_dout); end
`ifdef CACHE_STAT_EN
        checks++; if (r_hits !== 32'h0) begin failures++; $display("[TB] FAIL reset_hits: got %0d want 0", r_hits); end
        checks++; if (r_misses !== 32'h0) begin failures++; $display("[TB] FAIL reset_misses: got %0d want 0", r_misses); end
`endif
    endtask

    task automatic test_cold_miss();
        logic fr, fm, bs, to; logic [31:0] d, ma; int g, nm;
        fetch(32'h40, 3, -1, fr, fm, d, g, nm, ma, bs, to);
        model_fill(32'h40);
        checks++; if (fr !== 1'b0) begin failures++; $display("[TB] FAIL cold_first_rdy: got %b want 0", fr); end
        checks++; if (ma !== 32'h40) begin failures++; $display("[TB] FAIL cold_madr: got %h want 00000040", ma); end
        checks++; if (bs !== 1'b1) begin failures++; $display("[TB] FAIL cold_busy: got %b want 1", bs); end
        checks++; if (to !== 1'b0) begin failures++; $display("[TB] FAIL cold_timeout: got %b want 0", to); end
        checks++; if (g != 2) begin failures++; $display("[TB] FAIL cold_latency: got %0d want 2", g); end
        checks++; if (nm != 1) begin failures++; $display("[TB] FAIL cold_nmiss: got %0d want 1", nm); end
        checks++; if (d !== 32'h0050_0093) begin failures++; $display("[TB] FAIL cold_dout: got %h want 00500093", d); end
    endtask

    task automatic test_hit_after_fill();
        logic fr, fm, bs, to; logic [31:0] d, ma; int g, nm;
        fetch(32'h40, 3, -1, fr, fm, d, g, nm, ma, bs, to);
        checks++; if (fr !== 1'b1) begin failures++; $display("[TB] FAIL hit_rdy: got %b want 1", fr); end
        checks++; if (fm !== 1'b0) begin failures++; $display("[TB] FAIL hit_mre: got %b want 0", fm); end
        checks++; if (d !== 32'h0050_0093) begin failures++; $display("[TB] FAIL hit_dout: got %h want 00500093", d); end
    endtask

    task automatic test_round_robin();
        logic [31:0] addrs [8] = '{32'h000, 32'h080, 32'h100, 32'h080, 32'h000, 32'h100, 32'h080, 32'h000};
        logic        exp   [8] = '{1'b0,    1'b0,    1'b0,    1'b1,    1'b0,    1'b1,    1'b0,    1'b1};
        logic fr, fm, bs, to; logic [31:0] d, ma; int g, nm;
        for (int i = 0; i < 8; i++) begin
            fetch(addrs[i], 2, -1, fr, fm, d, g, nm, ma, bs, to);
            if (!exp[i]) model_fill(addrs[i]);
            checks++;
            if (fr !== exp[i]) begin failures++; $display("[TB] FAIL rr_hit[%0d] adr %h: got %b want %b", i, addrs[i], fr, exp[i]); end
            checks++;
            if (d !== mem_word(addrs[i]) || to) begin failures++; $display("[TB] FAIL rr_dout[%0d]: got %h want %h", i, d, mem_word(addrs[i])); end
        end
    endtask

    task automatic test_flush_miss();
        logic fr, fm, bs, to; logic [31:0] d, ma; int g, nm;
        fetch(32'h200, 2, 0, fr, fm, d, g, nm, ma, bs, to);
        model_fill(32'h200); model_flush(); model_fill(32'h200);
        checks++; if (nm != 2) begin failures++; $display("[TB] FAIL flush_miss_nmiss: got %0d want 2", nm); end
        checks++; if (d !== mem_word(32'h200) || to) begin failures++; $display("[TB] FAIL flush_miss_dout: got %h want %h", d, mem_word(32'h200)); end
        fetch(32'h40, 2, -1, fr, fm, d, g, nm, ma, bs, to);
        model_fill(32'h40);
        checks++; if (fr !== 1'b0) begin failures++; $display("[TB] FAIL flush_old_line: got hit %b want 0", fr); end
        checks++; if (ma !== 32'h40) begin failures++; $display("[TB] FAIL flush_old_madr: got %h want 00000040", ma); end
    endtask

    task automatic test_flush_idle();
        logic fr, fm, bs, to; logic [31:0] d, ma; int g, nm;
        @(negedge w_clk);
        w_req = 1'b1; w_adr = 32'h200; w_inv = 1'b1;
        #1;
        checks++; if (w_rdy !== 1'b1) begin failures++; $display("[TB] FAIL flush_idle_rdy: got %b want 1", w_rdy); end
        checks++; if (w_dout !== mem_word(32'h200)) begin failures++; $display("[TB] FAIL flush_idle_dout: got %h want %h", w_dout, mem_word(32'h200)); end
        @(negedge w_clk);
        w_req = 1'b0; w_inv = 1'b0;
        model_flush();
        fetch(32'h200, 1, -1, fr, fm, d, g, nm, ma, bs, to);
        model_fill(32'h200);
        checks++; if (fr !== 1'b0) begin failures++; $display("[TB] FAIL flush_idle_after: got hit %b want 0", fr); end
    endtask

    task automatic test_reset_mid_miss();
        logic fr, fm, bs, to; logic [31:0] d, ma; int g, nm;
        do_reset();
        @(negedge w_clk);
        w_req = 1'b1; w_adr = 32'h200;
        @(negedge w_clk);
        #1;
        checks++; if (w_mre !== 1'b1) begin failures++; $display("[TB] FAIL rstmiss_in_miss: got mre %b want 1", w_mre); end
        w_rst = 1'b1; w_req = 1'b0;
        @(negedge w_clk);
        w_rst = 1'b0;
        #1;
        checks++; if (w_mre !== 1'b0) begin failures++; $display("[TB] FAIL rstmiss_mre: got %b want 0", w_mre); end
        @(negedge w_clk);
        w_moe = 1'b1; w_mdata = 32'hDEAD_BEEF;
        @(negedge w_clk);
        w_moe = 1'b0;
        #1;
        checks++; if (w_busy !== 1'b0 || w_mre !== 1'b0) begin failures++; $display("[TB] FAIL rstmiss_stray_moe: got busy %b mre %b want 0 0", w_busy, w_mre); end
        model_flush();
        fetch(32'h200, 2, -1, fr, fm, d, g, nm, ma, bs, to);
        model_fill(32'h200);
        checks++; if (fr !== 1'b0) begin failures++; $display("[TB] FAIL rstmiss_valid: got hit %b want 0", fr); end
        checks++; if (d !== mem_word(32'h200) || nm != 1) begin failures++; $display("[TB] FAIL rstmiss_refill: got %h/%0d want %h/1", d, nm, mem_word(32'h200)); end
    endtask

    task automatic test_random();
        logic fr, fm, bs, to, exp; logic [31:0] a, d, ma; int g, nm;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                @(negedge w_clk); w_inv = 1'b1;
                @(negedge w_clk); w_inv = 1'b0;
                model_flush();
            end
            a = (32'($urandom_range(0, 5)) << (2 + $clog2(SETS))) |
                (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            exp = model_hit(a);
            fetch(a, $urandom_range(1, 4), -1, fr, fm, d, g, nm, ma, bs, to);
            if (!exp) model_fill(a);
            checks++;
            if (fr !== exp || nm != (exp ? 0 : 1) || to) begin
                failures++; $display("[TB] FAIL rand_hit[%0d] adr %h: got hit %b misses %0d want hit %b", i, a, fr, nm, exp);
            end
            checks++;
            if (d !== mem_word(a)) begin failures++; $display("[TB] FAIL rand_dout[%0d] adr %h: got %h want %h", i, a, d, mem_word(a)); end
        end
    endtask

`ifdef CACHE_STAT_EN
    task automatic test_stats();
        logic fr, fm, bs, to; logic [31:0] d, ma; int g, nm;
        do_reset();
        for (int i = 0; i < 4; i++) fetch(32'h40, 3, -1, fr, fm, d, g, nm, ma, bs, to);
        @(negedge w_clk);
        w_req = 1'b1; w_adr = 32'h80;
        @(negedge w_clk);
        #1;
        checks++; if (r_hits !== 32'd4) begin failures++; $display("[TB] FAIL stat_hits: got %0d want 4", r_hits); end
        checks++; if (r_misses !== 32'd2) begin failures++; $display("[TB] FAIL stat_misses: got %0d want 2", r_misses); end
        w_req = 1'b0;
        do_reset();
    endtask
`endif

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_cold_miss();
        test_hit_after_fill();
        test_round_robin();
        test_flush_miss();
        test_flush_idle();
        test_reset_mid_miss();
        test_random();
`ifdef CACHE_STAT_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
